// File: rtl/image_streamer_if.sv
// image_streamer_if: word-memory read bus between the image streamer and its frame store
// master: mem_rd (read strobe), mem_addr (word address); slave: mem_data (read data, one cycle after mem_rd)
interface image_streamer_if #(
  parameter int ADDR_W = 9,
  parameter int WORD_W = 32
);
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_data;
  modport master (output mem_rd, mem_addr, input mem_data);
  modport slave (input mem_rd, mem_addr, output mem_data);
endinterface

// File: rtl/image_streamer.sv
// image_streamer: serialises a bit-packed black-and-white image from word memory onto the linebuffer input
// Ports: clk; rst (asynchronous, active low); start/stop/resume frame control;
//   mem (image_streamer_if.master) word read bus; d_out/hold serial pixel and linebuffer hold;
//   x/y coordinate of the pixel on d_out; match_x/match_y coordinate latched on stop; busy/done status.
// IMAGE_STREAMER_PREFETCH_EN: reads the next word while the current word's bit 1 is on d_out,
//   removing the two hold cycles between words.
module image_streamer #(
  parameter int IMG_W  = 100,
  parameter int IMG_H  = 100,
  parameter int WORD_W = 32,
  parameter int ADDR_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             resume,
  image_streamer_if.master mem,
  output logic             d_out,
  output logic             hold,
  output logic [7:0]       x,
  output logic [7:0]       y,
  output logic [7:0]       match_x,
  output logic [7:0]       match_y,
  output logic             busy,
  output logic             done
);
`ifdef IMAGE_STREAMER_PREFETCH_EN
  localparam bit PF = 1'b1;
`else
  localparam bit PF = 1'b0;
`endif
  localparam int N = IMG_W * IMG_H;
  localparam int PW = $clog2(N + 1);
  localparam int BW = $clog2(WORD_W);
  localparam logic [PW-1:0] NP = PW'(N);
  localparam logic [7:0] XL = 8'(IMG_W - 1);
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, SHIFT, HALT, DONE} state_t;
  state_t state, nxt;
  // n is the index of the next pixel to emit; x/y always hold the last emitted pixel
  logic [PW-1:0] n;
  logic [BW-1:0] off;
  logic [WORD_W-1:0] sr, w;
  logic pf, restart, emit, pf_issue;
  always_comb begin
    off = BW'(n % WORD_W);
    restart = start && (state inside {IDLE, HALT, DONE});
    nxt = state;
    case (state)
      IDLE, DONE: nxt = start ? FETCH : state;
      FETCH:      nxt = stop ? HALT : WAIT;
      WAIT:       nxt = stop ? HALT : SHIFT;
      SHIFT:      nxt = stop ? HALT : n == NP ? DONE : (off == '0 && !pf) ? FETCH : SHIFT;
      HALT:       nxt = start ? FETCH : !resume ? HALT : n == NP ? DONE : FETCH;
      default:    nxt = IDLE;
    endcase
    emit = nxt == SHIFT;
    // a freshly read word is aligned so a resume mid-word starts at the right bit
    w = (state == WAIT || off == '0) ? mem.mem_data << off : sr;
    pf_issue = PF && emit && off == BW'(WORD_W - 2) && n < NP - PW'(2);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      n            <= '0;
      sr           <= '0;
      pf           <= 1'b0;
      mem.mem_rd   <= 1'b0;
      mem.mem_addr <= '0;
      d_out        <= 1'b0;
      hold         <= 1'b1;
      x            <= '0;
      y            <= '0;
      match_x      <= '0;
      match_y      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state      <= nxt;
      hold       <= !emit;
      busy       <= nxt inside {FETCH, WAIT, SHIFT};
      done       <= nxt == DONE;
      mem.mem_rd <= nxt == FETCH || pf_issue;
      pf         <= mem.mem_rd && state == SHIFT && emit;
      if (nxt == FETCH) mem.mem_addr <= restart ? '0 : ADDR_W'(n / WORD_W);
      else if (pf_issue) mem.mem_addr <= ADDR_W'(n / WORD_W + 1);
      n     <= restart ? '0 : emit ? n + PW'(1) : n;
      d_out <= emit && w[WORD_W-1];
      if (emit) sr <= w << 1;
      if (restart || (emit && n == '0)) begin
        x <= '0;
        y <= '0;
      end else if (emit) begin
        x <= x == XL ? '0 : x + 8'd1;
        y <= x == XL ? y + 8'd1 : y;
      end
      if (stop && state inside {FETCH, WAIT, SHIFT}) begin
        match_x <= x;
        match_y <= y;
      end
    end
  end
endmodule

// File: tb/tb_image_streamer.sv
// tb_image_streamer: directed table and frame-level sequences for image_streamer
module tb_image_streamer;
`ifdef IMAGE_STREAMER_PREFETCH_EN
  localparam int FRAME = 10002;
`else
  localparam int FRAME = 10626;
`endif
  typedef struct {
    logic st, sp, rs;
    int hold, rd, busy, done, d, x, y, mx, my, addr;
  } vec_t;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, stop = 1'b0, resume = 1'b0;
  logic d_out, hold, busy, done;
  logic [7:0] x, y, match_x, match_y;
  logic [31:0] mem [0:511];
  int nchk = 0, nerr = 0;
  int ep, ew, n_emit, bad, ones, done_cyc, fx, fy, x99, y99, x100, y100, n_rd, rd_bad;
  bit hit;
  vec_t tv [19];
  image_streamer_if #(.ADDR_W(9), .WORD_W(32)) bus ();
  image_streamer dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .resume(resume), .mem(bus),
    .d_out(d_out), .hold(hold), .x(x), .y(y), .match_x(match_x), .match_y(match_y),
    .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (bus.mem_rd) bus.mem_data <= mem[bus.mem_addr];
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic chk_opt(input string name, input logic [31:0] act, input int exp);
    if (exp >= 0) check(name, act, exp);
  endtask
  function automatic logic pix(input int p);
    logic [31:0] wd;
    wd = mem[p / 32];
    return wd[31 - p % 32];
  endfunction
  task automatic run(input bit st, input bit rs, input int stop_p);
    int cyc = 0;
    n_emit = 0; bad = 0; ones = 0; done_cyc = -1; fx = -1; fy = -1; n_rd = 0; rd_bad = 0; hit = 0;
    start = st; resume = rs;
    tick();
    start = 0; resume = 0;
    while (cyc < 12000 && done_cyc < 0 && !hit) begin
      if (bus.mem_rd) begin
        if (int'(bus.mem_addr) != ew) rd_bad++;
        ew++;
        n_rd++;
      end
      if (done) done_cyc = cyc;
      else if (!hold) begin
        if (fx < 0) begin fx = x; fy = y; end
        if (ep == 99) begin x99 = x; y99 = y; end
        if (ep == 100) begin x100 = x; y100 = y; end
        if (x !== 8'(ep % 100) || y !== 8'(ep / 100) || d_out !== pix(ep)) bad++;
        ones += int'(d_out);
        n_emit++;
        if (ep == stop_p) begin hit = 1; stop = 1; end
        ep++;
      end
      tick();
      cyc++;
    end
    stop = 0;
  endtask
  initial begin
    tv[0]  = '{0,0,0, 1,0,0,0,-1,  0, 0, 0, 0,-1};
    tv[1]  = '{1,0,0, 1,1,1,0,-1, -1,-1, 0, 0, 0};
    tv[2]  = '{0,0,0, 1,0,1,0,-1, -1,-1, 0, 0,-1};
    tv[3]  = '{0,0,0, 0,0,1,0, 1,  0, 0, 0, 0,-1};
    tv[4]  = '{0,0,0, 0,0,1,0, 1,  1, 0, 0, 0,-1};
    tv[5]  = '{0,1,0, 1,0,0,0,-1,  1, 0, 1, 0,-1};
    tv[6]  = '{0,1,0, 1,0,0,0,-1,  1, 0, 1, 0,-1};
    tv[7]  = '{0,0,1, 1,1,1,0,-1, -1,-1, 1, 0, 0};
    tv[8]  = '{0,0,0, 1,0,1,0,-1, -1,-1, 1, 0,-1};
    tv[9]  = '{0,0,0, 0,0,1,0, 0,  2, 0, 1, 0,-1};
    tv[10] = '{0,0,0, 0,0,1,0, 0,  3, 0, 1, 0,-1};
    tv[11] = '{0,0,0, 0,0,1,0, 1,  4, 0, 1, 0,-1};
    tv[12] = '{0,1,0, 1,0,0,0,-1,  4, 0, 4, 0,-1};
    tv[13] = '{1,0,1, 1,1,1,0,-1, -1,-1, 4, 0, 0};
    tv[14] = '{0,1,0, 1,0,0,0,-1, -1,-1,-1,-1,-1};
    tv[15] = '{0,0,1, 1,1,1,0,-1, -1,-1,-1,-1, 0};
    tv[16] = '{0,0,0, 1,0,1,0,-1, -1,-1,-1,-1,-1};
    tv[17] = '{0,0,0, 0,0,1,0, 1,  0, 0,-1,-1,-1};
    tv[18] = '{0,0,0, 0,0,1,0, 1,  1, 0,-1,-1,-1};
    for (int k = 0; k < 512; k++) mem[k] = 32'h0;
    mem[0] = 32'hC800_0001;
    repeat (3) tick();
    check("rst hold", hold, 1); check("rst mem_rd", bus.mem_rd, 0); check("rst addr", bus.mem_addr, 0);
    check("rst d_out", d_out, 0); check("rst x", x, 0); check("rst y", y, 0);
    check("rst match_x", match_x, 0); check("rst match_y", match_y, 0);
    check("rst busy", busy, 0); check("rst done", done, 0);
    rst = 1;
    tick();
    for (int i = 0; i < 19; i++) begin
      start = tv[i].st; stop = tv[i].sp; resume = tv[i].rs;
      tick();
      start = 0; stop = 0; resume = 0;
      chk_opt($sformatf("v%0d hold", i), hold, tv[i].hold);
      chk_opt($sformatf("v%0d mem_rd", i), bus.mem_rd, tv[i].rd);
      chk_opt($sformatf("v%0d busy", i), busy, tv[i].busy);
      chk_opt($sformatf("v%0d done", i), done, tv[i].done);
      chk_opt($sformatf("v%0d d_out", i), d_out, tv[i].d);
      chk_opt($sformatf("v%0d x", i), x, tv[i].x);
      chk_opt($sformatf("v%0d y", i), y, tv[i].y);
      chk_opt($sformatf("v%0d match_x", i), match_x, tv[i].mx);
      chk_opt($sformatf("v%0d match_y", i), match_y, tv[i].my);
      chk_opt($sformatf("v%0d mem_addr", i), bus.mem_addr, tv[i].addr);
    end
    rst = 0;
    tick();
    check("mid rst hold", hold, 1); check("mid rst mem_rd", bus.mem_rd, 0);
    check("mid rst x", x, 0); check("mid rst y", y, 0);
    check("mid rst done", done, 0); check("mid rst busy", busy, 0); check("mid rst d_out", d_out, 0);
    repeat (4) tick();
    rst = 1;
    repeat (3) tick();
    check("idle hold", hold, 1); check("idle busy", busy, 0);
    check("idle mem_rd", bus.mem_rd, 0); check("idle done", done, 0);
    mem[0] = 32'h8000_0001;
    ep = 0; ew = 0;
    run(1, 0, -1);
    check("frame done cycle", done_cyc, FRAME);
    check("frame pixels", n_emit, 10000);
    check("frame pixel errors", bad, 0);
    check("frame ones", ones, 2);
    check("p99 x", x99, 99); check("p99 y", y99, 0);
    check("p100 x", x100, 0); check("p100 y", y100, 1);
    check("frame reads", n_rd, 313);
    check("frame read addr errors", rd_bad, 0);
    check("done x", x, 99); check("done y", y, 99); check("done flag", done, 1); check("done hold", hold, 1);
    for (int k = 0; k < 313; k++) mem[k] = $urandom;
    ep = 0; ew = 0;
    run(1, 0, 1257);
    check("mid stop taken", hit, 1);
    check("mid stop hold", hold, 1); check("mid stop busy", busy, 0);
    check("mid stop match_x", match_x, 57); check("mid stop match_y", match_y, 12);
    check("mid stop pixel errors", bad, 0);
    ew = 1258 / 32;
    run(0, 1, -1);
    check("resume first x", fx, 58); check("resume first y", fy, 12);
    check("resume pixel errors", bad, 0);
    check("resume read addr errors", rd_bad, 0);
    check("resume completes", done_cyc >= 0, 1);
    check("resume pixels", n_emit, 10000 - 1258);
    ep = 0; ew = 0;
    run(1, 0, 9999);
    check("last stop taken", hit, 1);
    check("last stop hold", hold, 1); check("last stop done", done, 0);
    check("last stop match_x", match_x, 99); check("last stop match_y", match_y, 99);
    resume = 1;
    tick();
    resume = 0;
    check("last resume done", done, 1); check("last resume hold", hold, 1);
    check("last resume mem_rd", bus.mem_rd, 0); check("last resume busy", busy, 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
